// File: rtl/seq_add_sub_unit.sv
// seq_add_sub_unit: multi-cycle two's-complement add/sub, CHUNK bits per clock,
// LSB slice first, with carry/overflow/zero flags and valid/ready handshakes.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              operand handshake (ready only in IDLE)
//   in_a, in_b, in_sub, in_cin     operands, op select, carry/borrow-in
//   out_valid/out_ready            result handshake (valid held in DONE)
//   out_result                     sum or difference
//   out_carry, out_overflow        raw MSB carry, signed overflow
//   out_zero                       final out_result == 0
//
// Build option: define ADDSUB_SATURATE_EN to clamp the result on signed
// overflow (0x7F..F when A is non-negative, 0x80..0 otherwise).
module seq_add_sub_unit #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_overflow,
    output logic             out_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             c_q;
    logic [CW-1:0]    cnt_q;

    logic             accept;
    logic             last;
    int               idx;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_nx;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] res_fin;
    logic             ovf;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt_q == CW'(NCHUNK - 1));

    // One slice of the ripple; the full result is assembled in acc so
    // that out_result only ever changes to a complete, final value.
    always_comb begin
        idx    = int'(cnt_q) * CHUNK;
        a_sl   = a_q[idx +: CHUNK];
        b_sl   = b_q[idx +: CHUNK];
        {c_nx, s_sl} = {1'b0, a_sl} + {1'b0, b_sl} + (CHUNK + 1)'(c_q);
        acc_nx = acc_q;
        acc_nx[idx +: CHUNK] = s_sl;
        // b_q already holds the effective (possibly inverted) operand.
        ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
              (acc_nx[WIDTH-1] != a_q[WIDTH-1]);
        res_fin = acc_nx;
`ifdef ADDSUB_SATURATE_EN
        if (ovf) begin
            res_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid) state_nx = BUSY;
            BUSY:    if (last) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= '0;
            b_q          <= '0;
            acc_q        <= '0;
            c_q          <= 1'b0;
            cnt_q        <= '0;
            out_result   <= '0;
            out_carry    <= 1'b0;
            out_overflow <= 1'b0;
            out_zero     <= 1'b0;
        end else if (accept) begin
            a_q   <= in_a;
            // Subtract is A + ~B + 1; borrow-in lowers the +1 to +0.
            b_q   <= in_sub ? ~in_b : in_b;
            c_q   <= in_sub ? ~in_cin : in_cin;
            cnt_q <= '0;
        end else if (state == BUSY) begin
            acc_q <= acc_nx;
            c_q   <= c_nx;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
                out_result   <= res_fin;
                out_carry    <= c_nx;
                out_overflow <= ovf;
                out_zero     <= (res_fin == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_add_sub_unit.sv
// tb_seq_add_sub_unit: directed and random checks of seq_add_sub_unit
// against an arithmetic reference model (WIDTH=64, CHUNK=16).
module tb_seq_add_sub_unit;

    localparam int NCHUNK = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;
    logic        out_carry;
    logic        out_overflow;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    seq_add_sub_unit #(.WIDTH(64), .CHUNK(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_sub       (in_sub),
        .in_cin       (in_cin),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_carry    (out_carry),
        .out_overflow (out_overflow),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the true operands.
    task automatic model(input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin,
                         output logic [63:0] r, output logic c,
                         output logic v);
        logic [64:0] f;
        logic [65:0] s;
        if (!sub) begin
            f = {1'b0, a} + {1'b0, b} + 65'(cin);
            r = f[63:0];
            c = f[64];
            s = {{2{a[63]}}, a} + {{2{b[63]}}, b} + 66'(cin);
        end else begin
            r = a - b - 64'(cin);
            c = ({1'b0, a} >= ({1'b0, b} + 65'(cin)));
            s = {{2{a[63]}}, a} - {{2{b[63]}}, b} - 66'(cin);
        end
        v = !(s[65:63] == 3'b000 || s[65:63] == 3'b111);
`ifdef ADDSUB_SATURATE_EN
        if (v) r = a[63] ? 64'h8000_0000_0000_0000
                         : 64'h7FFF_FFFF_FFFF_FFFF;
`endif
    endtask

    task automatic start(input logic [63:0] a, input logic [63:0] b,
                         input logic sub, input logic cin);
        @(negedge clk);
        chk("ready_before", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_sub = sub; in_cin = cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("no_valid_at_accept", 64'(out_valid), 64'd0);
        chk("busy_not_ready", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) n = 99;
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("valid_drop", 64'(out_valid), 64'd0);
        chk("ready_back", 64'(in_ready), 64'd1);
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                          input logic sub, input logic cin,
                          input logic [63:0] er, input logic ec,
                          input logic ev);
        int n;
        start(a, b, sub, cin);
        wait_done(n);
        chk("latency", 64'(n), 64'(NCHUNK));
        chk("result", out_result, er);
        chk("carry", 64'(out_carry), 64'(ec));
        chk("overflow", 64'(out_overflow), 64'(ev));
        chk("zero", 64'(out_zero), 64'(er == 64'd0));
        drain();
    endtask

    task automatic run_rand(input logic [63:0] a, input logic [63:0] b,
                            input logic sub, input logic cin);
        logic [63:0] r;
        logic c, v;
        model(a, b, sub, cin, r, c, v);
        run_op(a, b, sub, cin, r, c, v);
    endtask

    initial begin : main
        logic [63:0] hold_r;
        logic [63:0] a, b;
        logic [63:0] sat_r;
        int n;

        #1;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", {61'd0, out_carry, out_overflow, out_zero}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(64'd76575785, 64'd5298, 1'b0, 1'b0,
               64'd76581083, 1'b0, 1'b0);
        run_op(64'd2319840, 64'd340, 1'b1, 1'b0,
               64'd2319500, 1'b1, 1'b0);
        run_op(64'd5, 64'd7, 1'b1, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               64'd0, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
        sat_r = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        sat_r = 64'h8000_0000_0000_0000;
`endif
        run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
               sat_r, 1'b0, 1'b1);
`ifdef ADDSUB_SATURATE_EN
        sat_r = 64'h8000_0000_0000_0000;
`else
        sat_r = 64'h7FFF_FFFF_FFFF_FFFF;
`endif
        run_op(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
               sat_r, 1'b1, 1'b1);
        run_op(64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0);
        run_op(64'hFFFF, 64'd0, 1'b0, 1'b1,
               64'h1_0000, 1'b0, 1'b0);

        // Hold in DONE with back-pressure while in_valid toggles.
        start(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
              1'b0, 1'b0);
        wait_done(n);
        chk("hold_latency", 64'(n), 64'(NCHUNK));
        hold_r = 64'h1234_5678_9ABC_DEF0 + 64'h0FED_CBA9_8765_4321;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = i[0];
            in_a = {$urandom, $urandom};
            in_b = {$urandom, $urandom};
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk("hold_result", out_result, hold_r);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain();
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("no_queued_op", 64'(out_valid), 64'd0);
        end

        // Asynchronous reset while slice 2 is in progress.
        start(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
              1'b0, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_result", out_result, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_rand(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555,
                 1'b0, 1'b1);

        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 6 == 1) b = ~a;
            if (i % 6 == 2) b = a;
            if (i % 6 == 3) a[63] = ~b[63];
            run_rand(a, b, 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

endmodule
